// File: rtl/exec_pkg.sv
// Shared execution-stage definitions: mul/div op codes, iteration FSM encoding
// and small op-classification helpers used by the ALU control decoder as well.
package exec_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// One radix-2 iteration on a 2*WIDTH accumulator: shift-add multiply
// (multiplier in the low half, LSB first) or restoring shift-subtract divide.
module muldiv_iter_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 divMode,
  input  logic [2*WIDTH-1:0]   accIn,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   accOut
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] trial_s;

  // Single iteration step; the partial remainder needs WIDTH+1 bits after the shift
  always_comb begin
    sum_s   = {1'b0, accIn[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    trial_s = accIn[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    accOut  = {1'b0, accIn[2*WIDTH-1:1]};
    if (divMode) begin
      if (!trial_s[WIDTH]) begin
        accOut = {trial_s[WIDTH-1:0], accIn[WIDTH-2:0], 1'b1};
      end else begin
        accOut = {accIn[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (accIn[0]) begin
        accOut = {sum_s, accIn[WIDTH-1:1]};
      end else begin
        accOut = {1'b0, accIn[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and a
// Start/Busy/Done handshake; operands are iterated as magnitudes, signs fixed at the end.
module exec_muldiv_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [2:0]         op_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   operand_r;
  logic [CW-1:0]      count_r;
  logic               negLo_r, negHi_r, divZero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, dbz_r;

  logic               accept_s, signedOp_s;
  logic [WIDTH-1:0]   magA_s, magB_s, quot_s, rem_s;
  logic [2*WIDTH-1:0] stepAcc_s, prod_s, fixHiLo_s;

  muldiv_iter_datapath #(.WIDTH(WIDTH)) u_iter (
    .divMode (isDivOp(op_r)),
    .accIn   (acc_r),
    .operand (operand_r),
    .accOut  (stepAcc_s)
  );

  // Operand magnitudes for acceptance; Flush beats Start
  always_comb begin
    accept_s   = Start && !busy_r && !Flush;
    signedOp_s = isSignedOp(Op);
    if (signedOp_s && OperandA[WIDTH-1]) begin
      magA_s = -OperandA;
    end else begin
      magA_s = OperandA;
    end
    if (signedOp_s && OperandB[WIDTH-1]) begin
      magB_s = -OperandB;
    end else begin
      magB_s = OperandB;
    end
  end

  // Sign correction and accumulation applied in FIX
  always_comb begin
    prod_s = negLo_r ? -acc_r : acc_r;
    quot_s = negLo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = negHi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    case (op_r)
      OP_MADD: fixHiLo_s = {hi_r, lo_r} + prod_s;
      OP_MSUB: fixHiLo_s = {hi_r, lo_r} - prod_s;
      OP_DIV, OP_DIVU: begin
        if (divZero_r) begin
          fixHiLo_s = acc_r;
        end else begin
          fixHiLo_s = {rem_s, quot_s};
        end
      end
      default: fixHiLo_s = prod_s;
    endcase
  end

  // FSM, iteration registers and architectural HI/LO
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_MULT;
      acc_r     <= {(2*WIDTH){1'b0}};
      operand_r <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      negLo_r   <= 1'b0;
      negHi_r   <= 1'b0;
      divZero_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            dbz_r <= 1'b0;
            case (Op)
              OP_MTHI: begin
                hi_r   <= OperandA;
                done_r <= 1'b1;
              end
              OP_MTLO: begin
                lo_r   <= OperandA;
                done_r <= 1'b1;
              end
              default: begin
                op_r    <= Op;
                count_r <= {CW{1'b0}};
                busy_r  <= 1'b1;
                negLo_r <= signedOp_s && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                negHi_r <= signedOp_s && OperandA[WIDTH-1];
                if (isDivOp(Op) && (OperandB == {WIDTH{1'b0}})) begin
                  // Raw dividend and all-ones quotient go straight to HI/LO
                  divZero_r <= 1'b1;
                  acc_r     <= {OperandA, {WIDTH{1'b1}}};
                  state_r   <= ST_FIX;
                end else if (isDivOp(Op)) begin
                  divZero_r <= 1'b0;
                  acc_r     <= {{WIDTH{1'b0}}, magA_s};
                  operand_r <= magB_s;
                  state_r   <= ST_RUN;
                end else begin
                  divZero_r <= 1'b0;
                  acc_r     <= {{WIDTH{1'b0}}, magB_s};
                  operand_r <= magA_s;
                  state_r   <= ST_RUN;
                end
              end
            endcase
          end
        end
        ST_RUN: begin
          if (Flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r   <= stepAcc_s;
            count_r <= count_r + CNT_ONE;
            if (count_r == LAST_CNT) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (Flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            {hi_r, lo_r} <= fixHiLo_s;
            dbz_r        <= divZero_r;
            done_r       <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign DivByZero = dbz_r;
  assign Hi        = hi_r;
  assign Lo        = lo_r;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Randomised and directed bench for exec_muldiv_unit (WIDTH=32) against an
// arithmetic reference model of HI/LO, DivByZero and completion latency.
module tb_exec_muldiv_unit;

  localparam int WIDTH = 32;

  logic             Clk, Rst, Start, Flush;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A, B;
  logic             Busy, Done, DivByZero;
  logic [WIDTH-1:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] mHi, mLo;
  logic        mDbz;

  exec_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (A),
    .OperandB  (B),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues the op and returns at the negedge where Done is seen
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int busyCnt;
    int expLat;
    int sa;
    int sb;
    logic [63:0] prod;
    sa = a;
    sb = b;
    mDbz = 1'b0;
    expLat = WIDTH + 1;
    prod = longint'(sa) * longint'(sb);
    case (op)
      3'd0: {mHi, mLo} = prod;
      3'd1: {mHi, mLo} = {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          mHi = a; mLo = 32'hFFFF_FFFF; mDbz = 1'b1; expLat = 1;
        end else if (op == 3'd3) begin
          mLo = a / b; mHi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          mLo = 32'h8000_0000; mHi = 32'd0;
        end else begin
          mLo = sa / sb; mHi = sa % sb;
        end
      end
      3'd4: {mHi, mLo} = {mHi, mLo} + prod;
      3'd5: {mHi, mLo} = {mHi, mLo} - prod;
      3'd6: mHi = a;
      default: mLo = a;
    endcase
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    if (op >= 3'd6) begin
      checkEq("mtDone", Done, 1);
      checkEq("mtBusy", Busy, 0);
    end else begin
      checkEq("doneLowAfterStart", Done, 0);
      checkEq("dbzClearedAtStart", DivByZero, 0);
      cyc = 1;
      busyCnt = 0;
      while (!Done && cyc < 100) begin
        busyCnt += int'(Busy);
        @(negedge Clk);
        cyc++;
      end
      checkEq("latency", cyc - 1, expLat);
      checkEq("busyCycles", busyCnt, expLat);
      checkEq("busyDropAtDone", Busy, 0);
    end
    checkEq("hi", Hi, mHi);
    checkEq("lo", Lo, mLo);
    checkEq("dbz", DivByZero, mDbz);
  endtask

  function automatic logic [31:0] pickVal();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    else return $urandom;
  endfunction

  initial begin
    int doneCnt;
    Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    mHi = 32'd0; mLo = 32'd0; mDbz = 1'b0;
    #12;
    checkEq("rstHi", Hi, 0);
    checkEq("rstLo", Lo, 0);
    checkEq("rstBusy", Busy, 0);
    checkEq("rstDone", Done, 0);
    checkEq("rstDbz", DivByZero, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    runOp(3'd0, 32'hFFFF_FFFD, 32'd5);
    checkEq("multNeg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp(3'd3, 32'd100, 32'd7);
    checkEq("divu", {Hi, Lo}, 64'h0000_0002_0000_000E);
    @(negedge Clk);
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2);
    checkEq("divNeg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checkEq("divMinByM1", {Hi, Lo}, 64'h0000_0000_8000_0000);
    runOp(3'd2, 32'd1234, 32'd0);
    checkEq("divZero", {Hi, Lo}, 64'h0000_04D2_FFFF_FFFF);
    repeat (3) @(negedge Clk);
    checkEq("dbzSticky", DivByZero, 1);
    runOp(3'd1, 32'd3, 32'd9);

    runOp(3'd6, 32'd1, 32'd0);
    runOp(3'd7, 32'hFFFF_FFFF, 32'd0);
    runOp(3'd4, 32'd1, 32'd1);
    checkEq("madd", {Hi, Lo}, 64'h0000_0002_0000_0000);
    runOp(3'd5, 32'd1, 32'd1);
    checkEq("msub", {Hi, Lo}, 64'h0000_0001_FFFF_FFFF);

    // Flush mid-MULTU with an ignored Start issued while busy
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(negedge Clk);
    Start = 1'b0;
    mDbz = 1'b0;
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 3'd6; A = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    checkEq("flushBusy", Busy, 0);
    checkEq("flushDone", Done, 0);
    doneCnt = 0;
    repeat (40) begin
      @(negedge Clk);
      doneCnt += int'(Done) + int'(Busy);
    end
    checkEq("flushNoDone", doneCnt, 0);
    checkEq("flushHiLo", {Hi, Lo}, {mHi, mLo});
    checkEq("flushDbz", DivByZero, mDbz);

    Start = 1'b1; Flush = 1'b1; Op = 3'd1; A = 32'd2; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    checkEq("flushWinsIdle", Busy, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra = pickVal();
      rb = pickVal();
      runOp(rop, ra, rb);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge Clk);
    end

    // Asynchronous reset mid-DIVU
    @(negedge Clk);
    runOp(3'd6, 32'h5555_AAAA, 32'd0);
    Start = 1'b1; Op = 3'd3; A = 32'hFFFF_0000; B = 32'd13;
    @(negedge Clk);
    Start = 1'b0;
    repeat (14) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    checkEq("asyncRstHi", Hi, 0);
    checkEq("asyncRstLo", Lo, 0);
    checkEq("asyncRstBusy", Busy, 0);
    checkEq("asyncRstDone", Done, 0);
    checkEq("asyncRstDbz", DivByZero, 0);
    mHi = 32'd0; mLo = 32'd0; mDbz = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    runOp(3'd1, 32'd6, 32'd7);
    checkEq("postRstMul", {Hi, Lo}, 64'h0000_0000_0000_002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_muldiv_unit.md
# exec_muldiv_unit

Parametrised iterative multiply/divide unit for the Execution stage, with architectural HI/LO registers. Generalises the single-cycle ALU path to operand width `WIDTH`, adds signed/unsigned multi-cycle multiply, divide, multiply-accumulate and HI/LO moves, and provides a Start/Busy/Done handshake. The pipeline controller uses `Busy` to stall the ID/EX register.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width; must be at least 4.

Ports:
- `Clk`  in  1: clock, rising-edge.
- `Rst`  in  1: asynchronous, active-low reset.
- `Start`  in  1: request a new operation; sampled only when `Busy`=0.
- `Op`  in  3: operation code (see Operation).
- `OperandA`  in  WIDTH: ReadData1; dividend or multiplicand.
- `OperandB`  in  WIDTH: ReadData2; divisor or multiplier.
- `Flush`  in  1: abort the in-flight operation.
- `Busy`  out  1: an operation is in progress; stall upstream.
- `Done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `DivByZero`  out  1: sticky until the next accepted Start; last divide had `OperandB`=0.
- `Hi`  out  WIDTH: HI register.
- `Lo`  out  WIDTH: LO register.

## Operation
- Op codes:
  - 0 MULT: signed.
  - 1 MULTU: unsigned.
  - 2 DIV: signed.
  - 3 DIVU: unsigned.
  - 4 MADD: signed, {Hi,Lo} += A*B.
  - 5 MSUB: signed, {Hi,Lo} -= A*B.
  - 6 MTHI: Hi <= A.
  - 7 MTLO: Lo <= A.
- State machine IDLE → RUN → FIX → IDLE.
  - IDLE:
    - On Start with Op 0–5, latch operand magnitudes and result sign, then go to RUN.
    - For a divide with B=0, go to FIX directly.
  - RUN:
    - Exactly `WIDTH` iterations, one per cycle.
    - Multiply: radix-2 shift-add.
    - Divide: restoring shift-subtract.
  - FIX:
    - Apply sign correction, accumulate for MADD/MSUB, write Hi/Lo, pulse Done, return to IDLE.
- Multiply results: Hi = upper WIDTH bits of the 2·WIDTH product, Lo = lower WIDTH bits. MADD/MSUB wrap modulo 2^(2·WIDTH).
- Divide results: Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - DIV of MIN by −1 gives Lo = MIN, Hi = 0 (natural wrap, no trap).
- Divide by zero: Hi = A, Lo = all ones, DivByZero = 1.
- MTHI/MTLO complete in IDLE: register written at the accepting edge, Done pulses that cycle, Busy stays 0.
- Start while Busy=1 is ignored; no queueing.
- Flush while Busy: return to IDLE at the next edge. Hi, Lo and DivByZero are unchanged and Done does not pulse. Flush in IDLE has no effect; Flush and Start in the same cycle means Flush wins.
- Reset (at any time, including mid-operation):
  - Hi, Lo = 0; Busy, Done, DivByZero = 0.
  - State goes to IDLE; the partial result is discarded.

## Timing
- Edge E0 accepts Start for Op 0–5; Busy is high from after E0.
- Normal completion:
  - RUN occupies edges E1..E_WIDTH; FIX executes at edge E_WIDTH+1.
  - At E_WIDTH+1, Hi/Lo update, Done goes high for one cycle, Busy drops.
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: Hi/Lo update and Done pulse at E1 (latency 1).
- MTHI/MTLO: update at E0; Done is high in the cycle after E0.
- Back-to-back: a Start asserted during the Done cycle is accepted at the next edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `exec_pkg`:
  - Op code localparams (`OP_MULT` … `OP_MTLO`).
  - State encoding IDLE/RUN/FIX.
  - Shared with the ALU control decoder.
- One sub-module, `muldiv_iter_datapath`: a WIDTH-generic iteration step (shift-add or shift-subtract on a 2·WIDTH accumulator, selected by mode).
- The FSM, sign handling and HI/LO registers live in the top module.

## Test plan
All scenarios use WIDTH=32.
- MULT A=−3 (FFFFFFFD), B=5 → Done at the 33rd edge; Hi=FFFFFFFF, Lo=FFFFFFF1; Busy high for exactly 33 cycles.
- DIVU 100/7 → Lo=0000000E, Hi=00000002. DIV −7/2 → Lo=FFFFFFFD, Hi=FFFFFFFF. DIV 80000000/FFFFFFFF → Lo=80000000, Hi=0.
- DIV 1234/0 → at E1, Hi=000004D2, Lo=FFFFFFFF, DivByZero=1. A following MULTU clears DivByZero at acceptance.
- MTHI 1, MTLO FFFFFFFF, then MADD 1×1 → Hi=00000002, Lo=00000000. MSUB 1×1 then restores Hi=00000001, Lo=FFFFFFFF.
- Start MULTU, Flush at cycle 10 → Busy low next cycle, no Done, Hi/Lo unchanged. A Start issued during Busy before the Flush is ignored.
- Drive Rst low mid-DIVU (cycle 15) → Hi=Lo=0, Busy=Done=0 immediately without a clock edge. After release, a new MULTU 6×7 gives Lo=0000002A.
